// File: rtl/tdm_demux4.sv
// Four-channel TDM receiver: frames a sync-marked serial stream into four WIDTH-bit slots
// and presents each completed slot on its own registered channel with valid strobes.
module tdm_demux4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             din,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic [3:0]       slot_valid,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StHunt, StRecv} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]            slot_q, slot_d;
    // Only the WIDTH-1 earlier bits are held; the last bit goes straight from din.
    logic [WIDTH-2:0]      shift_q, shift_d;
    logic [WIDTH-1:0]      ch_q [4];
    logic [WIDTH-1:0]      ch_d [4];
    logic [3:0]            slot_valid_q, slot_valid_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  sync_err_q, sync_err_d;
    logic                  busy_q;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        slot_d        = slot_q;
        shift_d       = shift_q;
        ch_d          = ch_q;
        slot_valid_d  = 4'b0000;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (bit_en) begin
            unique case (state_q)
                StHunt: begin
                    if (frame_sync) begin
                        shift_d   = (WIDTH-1)'(din);
                        bit_cnt_d = CntW'(1);
                        slot_d    = 2'd0;
                        state_d   = StRecv;
                    end
                end
                StRecv: begin
                    if (frame_sync) begin
                        // Sync mid-frame: drop the partial slot and restart on this bit.
                        sync_err_d = 1'b1;
                        shift_d    = (WIDTH-1)'(din);
                        bit_cnt_d  = CntW'(1);
                        slot_d     = 2'd0;
                    end else if (bit_cnt_q == LastBit) begin
                        ch_d[slot_q]         = {shift_q, din};
                        slot_valid_d[slot_q] = 1'b1;
                        bit_cnt_d            = '0;
                        slot_d               = slot_q + 2'd1;
                        if (slot_q == 2'd3) begin
                            frame_valid_d = 1'b1;
                            state_d       = StHunt;
                        end
                    end else begin
                        shift_d   = (WIDTH-1)'({shift_q, din});
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StHunt;
            bit_cnt_q     <= '0;
            slot_q        <= 2'd0;
            shift_q       <= '0;
            ch_q[0]       <= '0;
            ch_q[1]       <= '0;
            ch_q[2]       <= '0;
            ch_q[3]       <= '0;
            slot_valid_q  <= 4'b0000;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            slot_q        <= slot_d;
            shift_q       <= shift_d;
            ch_q[0]       <= ch_d[0];
            ch_q[1]       <= ch_d[1];
            ch_q[2]       <= ch_d[2];
            ch_q[3]       <= ch_d[3];
            slot_valid_q  <= slot_valid_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            busy_q        <= (state_d == StRecv);
        end
    end

    assign ch0         = ch_q[0];
    assign ch1         = ch_q[1];
    assign ch2         = ch_q[2];
    assign ch3         = ch_q[3];
    assign slot_valid  = slot_valid_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed and random serial streams checked every cycle against a
// frame-position model (bit index since sync, slot = index / W).
module tb_tdm_demux4;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         bit_en;
    logic         din;
    logic         frame_sync;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic [3:0]   slot_valid;
    logic         frame_valid;
    logic         sync_err;
    logic         busy;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_en      (bit_en),
        .din         (din),
        .frame_sync  (frame_sync),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2),
        .ch3         (ch3),
        .slot_valid  (slot_valid),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    bit           in_frame;
    int unsigned  pos;
    int unsigned  word;
    logic [W-1:0] e_ch [4];
    logic [3:0]   e_sv;
    logic         e_fv;
    logic         e_se;
    logic         e_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_all();
        check("ch0", 32'(ch0), 32'(e_ch[0]));
        check("ch1", 32'(ch1), 32'(e_ch[1]));
        check("ch2", 32'(ch2), 32'(e_ch[2]));
        check("ch3", 32'(ch3), 32'(e_ch[3]));
        check("slot_valid", 32'(slot_valid), 32'(e_sv));
        check("frame_valid", 32'(frame_valid), 32'(e_fv));
        check("sync_err", 32'(sync_err), 32'(e_se));
        check("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic model_reset();
        in_frame = 1'b0;
        pos      = 0;
        word     = 0;
        for (int k = 0; k < 4; k++) e_ch[k] = '0;
        e_sv   = '0;
        e_fv   = 1'b0;
        e_se   = 1'b0;
        e_busy = 1'b0;
    endtask

    task automatic model_update(input logic en, input logic d, input logic fs);
        e_sv = '0;
        e_fv = 1'b0;
        e_se = 1'b0;
        if (en) begin
            if (fs) begin
                if (in_frame) e_se = 1'b1;
                in_frame = 1'b1;
                pos      = 0;
                word     = 0;
            end
            if (in_frame) begin
                word = (word << 1) | 32'(d);
                pos++;
                if (pos % W == 0) begin
                    e_ch[pos / W - 1] = word[W-1:0];
                    e_sv = 4'(1 << (pos / W - 1));
                    word = 0;
                    if (pos == 4 * W) begin
                        e_fv     = 1'b1;
                        in_frame = 1'b0;
                    end
                end
            end
        end
        e_busy = in_frame;
    endtask

    task automatic step(input logic en, input logic d, input logic fs);
        bit_en     = en;
        din        = d;
        frame_sync = fs;
        @(posedge clk);
        model_update(en, d, fs);
        #1 check_all();
    endtask

    task automatic send_word(input logic [W-1:0] val, input bit sync_first, input bit gapped);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, val[i], (sync_first && i == W - 1) ? 1'b1 : 1'b0);
            if (gapped) step(1'b0, ~val[i], 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w0, input logic [W-1:0] w1,
                              input logic [W-1:0] w2, input logic [W-1:0] w3,
                              input bit gapped);
        send_word(w0, 1'b1, gapped);
        send_word(w1, 1'b0, gapped);
        send_word(w2, 1'b0, gapped);
        send_word(w3, 1'b0, gapped);
    endtask

    task automatic check_chans(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic [W-1:0] d);
        check({tag, "_ch0"}, 32'(ch0), 32'(a));
        check({tag, "_ch1"}, 32'(ch1), 32'(b));
        check({tag, "_ch2"}, 32'(ch2), 32'(c));
        check({tag, "_ch3"}, 32'(ch3), 32'(d));
    endtask

    initial begin
        rst_n      = 1'b0;
        bit_en     = 1'b0;
        din        = 1'b0;
        frame_sync = 1'b0;
        model_reset();

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            bit_en     = 1'($urandom_range(0, 1));
            din        = 1'($urandom_range(0, 1));
            frame_sync = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 check_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);

        // Single contiguous frame, then the same frame with gapped enables.
        send_frame(4'hA, 4'h5, 4'hC, 4'h3, 1'b0);
        check_chans("frame", 4'hA, 4'h5, 4'hC, 4'h3);
        step(1'b0, 1'b0, 1'b0);
        send_frame(4'h6, 4'h9, 4'h1, 4'hE, 1'b1);
        check_chans("gapped", 4'h6, 4'h9, 4'h1, 4'hE);

        // Resync on slot 1 bit 2; the sync bit starts frame 1,2,3,4.
        send_word(4'hA, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        send_frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
        check_chans("resync", 4'h1, 4'h2, 4'h3, 4'h4);

        // Sync on the last bit of slot 3 aborts that slot.
        send_word(4'h7, 1'b1, 1'b0);
        send_word(4'h8, 1'b0, 1'b0);
        send_word(4'hB, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        send_word(4'h2, 1'b0, 1'b0);
        send_word(4'h3, 1'b0, 1'b0);
        send_word(4'h4, 1'b0, 1'b0);
        check_chans("late_sync", 4'h9, 4'h2, 4'h3, 4'h4);

        // No sync: 64 enabled bits change nothing.
        for (int i = 0; i < 64; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);

        // Back-to-back frames.
        for (int v = 0; v < 16; v++) begin
            for (int f = 0; f < 4; f++) send_frame(4'(v), 4'(v), 4'(v), 4'(v), 1'b0);
        end
        check_chans("b2b", 4'hF, 4'hF, 4'hF, 4'hF);

        // Random stream with occasional syncs.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 23) == 0));
        end

        // Asynchronous reset at slot 2 bit 1.
        step(1'b0, 1'b0, 1'b0);
        send_word(4'hA, 1'b1, 1'b0);
        send_word(4'h5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        bit_en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(4'h6, 4'h9, 4'hE, 4'h7, 1'b0);
        check_chans("after_rst", 4'h6, 4'h9, 4'hE, 4'h7);
        step(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
